// File: rtl/acq_window_ctrl.sv
// acq_window_ctrl: windowed multi-channel ADC capture, serialised channel-by-channel into a FIFO
module acq_window_ctrl #(
  parameter int AD_WIDTH  = 8,
  parameter int NUM_CH    = 2,
  parameter int WIN_W     = 20,
  parameter int TEST_BASE = 88
) (
  input  logic                       clk_100,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WIN_W-1:0]           win_len,
  input  logic                       test_mode,
  input  logic                       adc_valid,
  input  logic [NUM_CH*AD_WIDTH-1:0] addata,
  input  logic                       fifo_full,
  output logic [AD_WIDTH-1:0]        fifo_din,
  output logic                       fifo_wr_en,
  output logic                       busy,
  output logic                       over_re,
  output logic [15:0]                sample_cnt,
  output logic [15:0]                drop_cnt
);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {IDLE, ACQ, DRAIN, DONE} state_t;
  state_t                     r_state, w_next;
  logic [WIN_W-1:0]           r_win_len, r_wcnt;
  logic                       r_test, r_ser_busy;
  logic [IW-1:0]              r_idx;
  logic [AD_WIDTH-1:0]        r_seq, w_word;
  logic [NUM_CH*AD_WIDTH-1:0] r_shadow, w_cap;
  logic                       w_last, w_free, w_term, w_abort;
  assign w_last  = r_ser_busy && !fifo_full && r_idx == IW'(NUM_CH-1);
  // The slot finishing its last write this cycle can take the next sample at once
  assign w_free  = !r_ser_busy || w_last;
  assign w_term  = r_wcnt == r_win_len - WIN_W'(1);
  assign w_abort = abort && (r_state == ACQ || r_state == DRAIN);
  assign w_word  = r_shadow[r_idx*AD_WIDTH +: AD_WIDTH];
  assign busy    = r_state != IDLE;
  always_comb begin
    w_cap = '0;
    for (int c = 0; c < NUM_CH; c++)
      w_cap[c*AD_WIDTH +: AD_WIDTH] = r_test ? AD_WIDTH'(TEST_BASE + int'(r_seq) + c)
                                             : addata[c*AD_WIDTH +: AD_WIDTH];
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? (win_len == '0 ? DONE : ACQ) : IDLE;
      ACQ:     w_next = abort ? IDLE : w_term ? DRAIN : ACQ;
      DRAIN:   w_next = abort ? IDLE : w_free ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_100 or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      r_win_len  <= '0;
      r_wcnt     <= '0;
      r_test     <= 1'b0;
      r_ser_busy <= 1'b0;
      r_idx      <= '0;
      r_seq      <= '0;
      r_shadow   <= '0;
      fifo_din   <= '0;
      fifo_wr_en <= 1'b0;
      over_re    <= 1'b0;
      sample_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      over_re    <= r_state == DONE;
      fifo_wr_en <= 1'b0;
      if (r_state == IDLE && start) begin
        r_win_len  <= win_len;
        r_test     <= test_mode;
        r_wcnt     <= '0;
        r_seq      <= '0;
        sample_cnt <= '0;
        drop_cnt   <= '0;
      end
      if (r_state == ACQ) r_wcnt <= r_wcnt + WIN_W'(1);
      if (w_abort) r_ser_busy <= 1'b0;
      else begin
        if (r_ser_busy && !fifo_full) begin
          fifo_din   <= w_word;
          fifo_wr_en <= 1'b1;
          r_idx      <= r_idx + IW'(1);
          if (w_last) r_ser_busy <= 1'b0;
        end
        if (r_state == ACQ && adc_valid) begin
          if (w_free) begin
            r_shadow   <= w_cap;
            r_ser_busy <= 1'b1;
            r_idx      <= '0;
            r_seq      <= r_seq + AD_WIDTH'(1);
            sample_cnt <= sample_cnt + 16'd1;
          end else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: doc/acq_window_ctrl.md
Name: acq_window_ctrl

Overview:
- Parametrised multi-channel ADC acquisition controller.
- On a start pulse it opens a programmable capture window and samples NUM_CH ADC channels on each valid strobe. It serialises the samples channel-by-channel into the UDP transmit FIFO and pulses over_re when the window closes.
- Sits between the ADC front end and the async FIFO feeding udpSend. It replaces the fixed 1,000,000-cycle timer and the hard-wired test byte with a runtime window length and a test-pattern mode.

Parameters:
- AD_WIDTH, 8, bits per ADC sample and per FIFO word (1..16).
- NUM_CH, 2, number of ADC channels packed on addata (1..8).
- WIN_W, 20, width of the window-length counter.
- TEST_BASE, 88, base value for test-pattern words.

Ports:
- clk_100 input 1: system clock; all logic on rising edge.
- rst input 1: asynchronous, active-high reset.
- start input 1: single-cycle pulse; begins an acquisition.
- abort input 1: single-cycle pulse; cancels an acquisition.
- win_len input WIN_W: window length in clk_100 cycles; latched on start.
- test_mode input 1: 1 = emit test pattern instead of addata; latched on start.
- adc_valid input 1: sample strobe from the ADC clock-enable logic.
- addata input NUM_CH*AD_WIDTH: channel c occupies bits [c*AD_WIDTH +: AD_WIDTH].
- fifo_full input 1: FIFO almost-full; asserted while at most 1 free slot remains.
- fifo_din output AD_WIDTH: registered FIFO write data.
- fifo_wr_en output 1: registered FIFO write enable.
- busy output 1: high in any state other than IDLE.
- over_re output 1: one-cycle pulse at acquisition end.
- sample_cnt output 16: samples accepted this acquisition; wraps at 65535.
- drop_cnt output 16: samples dropped this acquisition; saturates at 65535.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; window counter, serializer index and sample sequence number all 0.
- State IDLE:
  - start → latch win_len and test_mode; clear sample_cnt and drop_cnt; clear sequence number.
  - Go to ACQ; if latched win_len == 0, go directly to DONE.
  - abort is ignored in IDLE.
- State ACQ:
  - Window counter increments every cycle from 0; the window is exactly win_len cycles.
  - At count == win_len-1, next state is DRAIN.
  - adc_valid while the serializer is idle: capture all NUM_CH channels into a shadow register, sample_cnt++, start serialising. This applies on the last window cycle too.
  - adc_valid while the serializer is busy: sample not captured; drop_cnt++ (saturating).
  - start in ACQ is ignored.
- Serializer:
  - Emits channel 0 first, up to NUM_CH-1, one word per cycle.
  - fifo_full is sampled each cycle. If it was low at cycle t, the word is presented with fifo_wr_en=1 at t+1; if high, the serializer stalls with fifo_wr_en=0 and the index held.
  - Completes after the NUM_CH-th write. With fifo_full held low, a sample occupies the serializer for exactly NUM_CH cycles.
- Test mode: word for channel c = TEST_BASE + seq + c, truncated to AD_WIDTH (mod 2^AD_WIDTH). seq increments per accepted sample.
- State DRAIN: no new samples are accepted and adc_valid does not count as a drop. Waits for the serializer to finish, then goes to DONE.
- State DONE: over_re=1 for exactly one cycle; next state IDLE. sample_cnt and drop_cnt hold until the next start.
- abort in ACQ or DRAIN:
  - Next state IDLE; serializer cleared; fifo_wr_en=0 from the next cycle.
  - No over_re pulse; partial channel groups may remain in the FIFO.
  - abort and start in the same cycle: abort wins.
- Window counter terminal and adc_valid in the same cycle: the sample is accepted, then the FSM moves to DRAIN.
- rst asserted mid-acquisition: immediate return to reset values; no over_re pulse.

Test Plan:
- NUM_CH=2, win_len=10, test_mode=0, addata=16'hB2A1, adc_valid at window cycles 0 and 4, fifo_full=0 → writes A1,B2,A1,B2; sample_cnt=2; drop_cnt=0; over_re pulses once; busy returns to 0.
- test_mode=1, win_len=20, adc_valid every 4th cycle → word pairs 88,89 / 89,90 / 90,91 / …; sample_cnt=5; drop_cnt=0.
- adc_valid on consecutive cycles with NUM_CH=2, win_len=8 → alternate samples dropped; sample_cnt=4; drop_cnt=4.
- fifo_full held high 5 cycles mid-serialisation → fifo_wr_en=0 during the stall; no word lost or duplicated; over_re delayed until the last write completes.
- win_len=0 → over_re pulses 2 cycles after start; no FIFO writes.
- abort 3 cycles into a 1000-cycle window → busy falls the next cycle; no over_re; a subsequent start runs normally with counters cleared. Async rst mid-write → all outputs 0 immediately.
